// File: rtl/mano_io_interrupt.sv
// mano_io_interrupt: Mano basic computer I/O registers, flags, printer handshake and interrupt logic.
//   CLK, CLR           : clock, asynchronous active-high reset
//   kbd_data/valid     : keyboard character in; kbd_ready = ~FGI
//   prn_data/valid     : OUTR to the printer, held until prn_ready
//   AC_low             : accumulator low bits, loaded into OUTR on OUT
//   INP..IOF           : decoded one-cycle I/O instruction strobes
//   t012_n, int_ack    : sequence-counter qualifier and interrupt-cycle completion
//   INPR, FGI, FGO, IEN, R : registered architectural state
//   skip               : combinational PC-increment request for SKI/SKO
module mano_io_interrupt #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [DATA_W-1:0] kbd_data,
    input  logic              kbd_valid,
    output logic              kbd_ready,
    output logic [DATA_W-1:0] prn_data,
    output logic              prn_valid,
    input  logic              prn_ready,
    input  logic [DATA_W-1:0] AC_low,
    input  logic              INP,
    input  logic              OUT,
    input  logic              SKI,
    input  logic              SKO,
    input  logic              ION,
    input  logic              IOF,
    input  logic              t012_n,
    input  logic              int_ack,
    output logic [DATA_W-1:0] INPR,
    output logic              FGI,
    output logic              FGO,
    output logic              IEN,
    output logic              R,
    output logic              skip
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] inpr_q, inpr_d, outr_q, outr_d;
    logic              fgi_q, fgi_d, ien_q, ien_d, r_q, r_d;
    logic              capture, fgo;

    // FGO is simply "printer idle", so it is registered through the state.
    assign fgo       = (state_q == IDLE);
    assign capture   = kbd_valid & ~fgi_q;
    assign kbd_ready = ~fgi_q;
    assign skip      = (SKI & fgi_q) | (SKO & fgo);

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            inpr_q  <= '0;
            outr_q  <= '0;
            fgi_q   <= 1'b0;
            ien_q   <= 1'b0;
            r_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            inpr_q  <= inpr_d;
            outr_q  <= outr_d;
            fgi_q   <= fgi_d;
            ien_q   <= ien_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        outr_d  = outr_q;
        inpr_d  = capture ? kbd_data : inpr_q;
        // A fresh capture only happens with FGI clear, so it owns the flag.
        fgi_d   = capture ? 1'b1 : (INP ? 1'b0 : fgi_q);
        ien_d   = (int_ack | IOF) ? 1'b0 : (ION ? 1'b1 : ien_q);
        r_d     = int_ack ? 1'b0 : ((t012_n & ien_q & (fgi_q | fgo)) ? 1'b1 : r_q);
        if (state_q == IDLE && OUT) begin
            state_d = SEND;
            outr_d  = AC_low;
        end else if (state_q == SEND && prn_ready) begin
            state_d = IDLE;
        end
    end

    assign INPR      = inpr_q;
    assign prn_data  = outr_q;
    assign prn_valid = (state_q == SEND);
    assign FGI       = fgi_q;
    assign FGO       = fgo;
    assign IEN       = ien_q;
    assign R         = r_q;
endmodule

// File: tb/tb_mano_io_interrupt.sv
// tb_mano_io_interrupt: directed and randomized checks of mano_io_interrupt against a behavioural model.
module tb_mano_io_interrupt;
    logic       CLK = 1'b0, CLR = 1'b0;
    logic [7:0] kbd_data = '0, AC_low = '0;
    logic       kbd_valid = 0, prn_ready = 0, INP = 0, OUT = 0, SKI = 0, SKO = 0;
    logic       ION = 0, IOF = 0, t012_n = 0, int_ack = 0;
    logic       kbd_ready, prn_valid, FGI, FGO, IEN, R, skip;
    logic [7:0] prn_data, INPR;

    int n_tests = 0, n_fail = 0;

    logic [7:0] m_inpr, m_outr;
    bit         m_fgi, m_busy, m_ien, m_r;

    mano_io_interrupt #(.DATA_W(8)) dut (
        .CLK(CLK), .CLR(CLR), .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready),
        .prn_data(prn_data), .prn_valid(prn_valid), .prn_ready(prn_ready), .AC_low(AC_low),
        .INP(INP), .OUT(OUT), .SKI(SKI), .SKO(SKO), .ION(ION), .IOF(IOF),
        .t012_n(t012_n), .int_ack(int_ack), .INPR(INPR), .FGI(FGI), .FGO(FGO),
        .IEN(IEN), .R(R), .skip(skip)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_inpr = 0; m_outr = 0; m_fgi = 0; m_busy = 0; m_ien = 0; m_r = 0;
    endtask

    // One clock edge of the architectural behaviour, all decisions on pre-edge values.
    task automatic model_edge();
        bit want_r, cap;
        want_r = t012_n && m_ien && (m_fgi || !m_busy);
        cap    = kbd_valid && !m_fgi;
        if (int_ack) m_r = 0; else if (want_r) m_r = 1;
        if (int_ack || IOF) m_ien = 0; else if (ION) m_ien = 1;
        if (cap) begin m_inpr = kbd_data; m_fgi = 1; end
        else if (INP) m_fgi = 0;
        if (!m_busy && OUT) begin m_busy = 1; m_outr = AC_low; end
        else if (m_busy && prn_ready) m_busy = 0;
    endtask

    task automatic check_regs(input string ph);
        chk({ph, ".INPR"}, INPR, m_inpr);
        chk({ph, ".prn_data"}, prn_data, m_outr);
        chk({ph, ".prn_valid"}, prn_valid, m_busy);
        chk({ph, ".FGO"}, FGO, !m_busy);
        chk({ph, ".FGI"}, FGI, m_fgi);
        chk({ph, ".IEN"}, IEN, m_ien);
        chk({ph, ".R"}, R, m_r);
        chk({ph, ".kbd_ready"}, kbd_ready, !m_fgi);
    endtask

    task automatic clear_strobes();
        INP = 0; OUT = 0; SKI = 0; SKO = 0; ION = 0; IOF = 0; int_ack = 0;
    endtask

    // Called at a negedge with inputs already set: checks skip, takes one edge, checks state.
    task automatic step();
        #1 chk("skip", skip, (SKI && m_fgi) || (SKO && !m_busy));
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_regs("step");
        clear_strobes();
    endtask

    task automatic do_reset();
        CLR = 1;
        model_reset();
        INP = 1; OUT = 1; ION = 1; kbd_valid = 1; t012_n = 1; AC_low = 8'hEE; kbd_data = 8'hDD;
        #1 check_regs("rst");
        @(posedge CLK);
        @(negedge CLK);
        check_regs("rst_hold");
        clear_strobes();
        kbd_valid = 0; t012_n = 0;
        CLR = 0;
    endtask

    initial begin
        @(negedge CLK);
        do_reset();
        // Keyboard path
        kbd_data = 8'h41; kbd_valid = 1; step(); kbd_valid = 0;
        chk("kbd.INPR41", INPR, 8'h41);
        chk("kbd.FGI", FGI, 1);
        chk("kbd.ready0", kbd_ready, 0);
        SKI = 1; #1 chk("kbd.skip", skip, 1); step();
        INP = 1; step();
        chk("kbd.INP_clr", FGI, 0);
        chk("kbd.INPR_hold", INPR, 8'h41);
        // Printer path and ignored OUT
        AC_low = 8'h5A; OUT = 1; step();
        chk("prn.valid", prn_valid, 1);
        chk("prn.data5A", prn_data, 8'h5A);
        chk("prn.FGO0", FGO, 0);
        AC_low = 8'hFF; OUT = 1; step();
        for (int i = 0; i < 4; i++) step();
        chk("prn.hold", prn_data, 8'h5A);
        chk("prn.hold_valid", prn_valid, 1);
        prn_ready = 1; step(); prn_ready = 0;
        chk("prn.done_FGO", FGO, 1);
        chk("prn.done_valid", prn_valid, 0);
        // Interrupt
        ION = 1; step();
        t012_n = 1; step(); t012_n = 0;
        chk("int.R1", R, 1);
        int_ack = 1; step();
        chk("int.R0", R, 0);
        chk("int.IEN0", IEN, 0);
        ION = 1; int_ack = 1; step();
        chk("int.ack_wins", IEN, 0);
        // Collision
        kbd_data = 8'h33; kbd_valid = 1; step();
        kbd_data = 8'h77; INP = 1; step();
        chk("col.FGI0", FGI, 0);
        chk("col.INPR33", INPR, 8'h33);
        step(); kbd_valid = 0;
        chk("col.INPR77", INPR, 8'h77);
        chk("col.FGI1", FGI, 1);
        // Asynchronous reset during SEND
        AC_low = 8'h12; OUT = 1; ION = 1; step();
        t012_n = 1; step(); t012_n = 0;
        chk("arst.pre_R", R, 1);
        #2 CLR = 1; model_reset();
        #1 chk("arst.valid", prn_valid, 0);
        chk("arst.FGO", FGO, 1);
        chk("arst.IEN", IEN, 0);
        chk("arst.R", R, 0);
        @(negedge CLK);
        do_reset();
        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            kbd_data  = 8'($urandom);
            AC_low    = 8'($urandom);
            kbd_valid = ($urandom_range(0, 2) == 0);
            prn_ready = ($urandom_range(0, 3) == 0);
            t012_n    = $urandom_range(0, 1);
            INP = ($urandom_range(0, 5) == 0);
            OUT = ($urandom_range(0, 5) == 0);
            SKI = ($urandom_range(0, 3) == 0);
            SKO = ($urandom_range(0, 3) == 0);
            ION = ($urandom_range(0, 4) == 0);
            IOF = ($urandom_range(0, 7) == 0);
            int_ack = ($urandom_range(0, 7) == 0);
            if (kbd_valid && !m_fgi) INP = 0;
            if ($urandom_range(0, 99) == 0) do_reset();
            else step();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mano_io_interrupt.md
MANO_IO_INTERRUPT -- requirements
Module: mano_io_interrupt

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the character width of INPR and OUTR.
REQ-002 SHALL have port CLK, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port CLR, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port kbd_data, input, DATA_W bits: keyboard character.
REQ-005 SHALL have port kbd_valid, input, 1 bit: keyboard character present.
REQ-006 SHALL have port kbd_ready, output, 1 bit: block can accept a character.
REQ-007 SHALL have port prn_data, output, DATA_W bits: OUTR contents to the printer.
REQ-008 SHALL have port prn_valid, output, 1 bit: printer character pending.
REQ-009 SHALL have port prn_ready, input, 1 bit: printer accepts the character.
REQ-010 SHALL have port AC_low, input, DATA_W bits: AC[DATA_W-1:0] from the accumulator.
REQ-011 SHALL have ports INP, OUT, SKI, SKO, ION, IOF, each input, 1 bit: decoded I/O instruction strobes (D7·I·T3), one cycle wide.
REQ-012 SHALL have port t012_n, input, 1 bit: high when the sequence counter is not in T0, T1 or T2.
REQ-013 SHALL have port int_ack, input, 1 bit: interrupt cycle complete (R·T2).
REQ-014 SHALL have port INPR, output, DATA_W bits: input register, to AC on INP.
REQ-015 SHALL have ports FGI, FGO, IEN and R, each output, 1 bit: input flag, output flag, interrupt enable and interrupt request.
REQ-016 SHALL have port skip, output, 1 bit: combinational request to increment PC.

Function
REQ-017 Keyboard handshake: kbd_ready SHALL equal ~FGI; a cycle with kbd_valid & kbd_ready SHALL load INPR <= kbd_data and set FGI on the same edge.
REQ-018 INP SHALL clear FGI on that edge; INPR SHALL hold its value until the next capture.
REQ-019 INP together with kbd_valid SHALL clear FGI and capture nothing, because kbd_ready was 0 in that cycle; capture SHALL occur no earlier than the following cycle.
REQ-020 Printer FSM states SHALL be IDLE (FGO=1, prn_valid=0) and SEND (FGO=0, prn_valid=1).
REQ-021 OUT in IDLE SHALL load OUTR <= AC_low and move to SEND.
REQ-022 SEND SHALL hold prn_data stable until prn_ready=1, then return to IDLE (FGO=1) on that edge.
REQ-023 OUT in SEND SHALL be ignored; OUTR SHALL be unchanged and the state SHALL remain SEND.
REQ-024 skip SHALL equal (SKI & FGI) | (SKO & FGO), evaluated combinationally in the strobe cycle.
REQ-025 ION SHALL set IEN; IOF SHALL clear IEN; int_ack SHALL clear IEN.
REQ-026 Priority on IEN when strobes coincide SHALL be int_ack, then IOF, then ION.
REQ-027 R SHALL be set on an edge where t012_n & IEN & (FGI | FGO) holds.
REQ-028 R SHALL be cleared by int_ack; int_ack SHALL win over a simultaneous set.
REQ-029 R SHALL use the IEN and flag values from before the edge (registered, one-cycle latency).
REQ-030 All outputs except skip and kbd_ready SHALL be registered.

Reset
REQ-031 CLR=1 SHALL immediately force INPR=0, OUTR=0, FGI=0, FGO=1 (printer IDLE), prn_valid=0, IEN=0 and R=0, independent of CLK.
REQ-032 Assertion of CLR in SEND SHALL drop prn_valid at once and discard the pending character.
REQ-033 Strobes and kbd_valid present while CLR=1 SHALL have no effect.

Verification
REQ-034 Keyboard path: after reset, kbd_data=8'h41 with kbd_valid for 1 cycle -> INPR=8'h41, FGI=1, kbd_ready=0 next cycle; SKI -> skip=1; INP -> FGI=0.
REQ-035 Printer path: AC_low=8'h5A, OUT -> prn_valid=1, prn_data=8'h5A, FGO=0; prn_ready held low 5 cycles -> unchanged; prn_ready=1 -> FGO=1, prn_valid=0.
REQ-036 Ignored OUT: a second OUT with AC_low=8'hFF during SEND -> prn_data stays 8'h5A.
REQ-037 Interrupt: ION, then t012_n=1 with FGO=1 -> R=1 one edge later; int_ack -> R=0 and IEN=0; int_ack with ION in the same cycle -> IEN=0.
REQ-038 Collision: INP and kbd_valid in the same cycle with FGI=1 -> FGI=0 and INPR unchanged; kbd_valid held -> capture on the next edge.
REQ-039 Mid-operation reset: CLR pulsed asynchronously between edges during SEND -> prn_valid=0, FGO=1, IEN=0, R=0 before the next edge.
